dfork_reg: RTL and testbench
============================

# dfork_reg

Registered dataflow fork for the CGRA datapath: takes one valid/ready token stream, typically the output of a processing-element FIFO, and replicates each token to `numOutputs` independent consumers. The consumers are neighbouring PEs or switch ports. Every branch has its own registered valid, so each consumer drains at its own pace. A new input token is accepted only once every branch has delivered, or is delivering, the previous one.

## Interface
- `dataWidth`, 32, token width in bits.
- `numOutputs`, 2, number of fork branches; legal range 1..8.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  dataWidth  input token.
- `dinValid`  in  1  input token present.
- `dinReady`  out  1  fork accepts `din` this cycle.
- `dout`  out  dataWidth  registered token, shared by all branches.
- `doutValid`  out  numOutputs  bit i: branch i holds an undelivered token.
- `doutReady`  in  numOutputs  bit i: consumer i takes the token this cycle.

## Operation
- State:
  - one data register `dout`.
  - per-branch valid bits `v[i]`, driven directly on `doutValid[i]`.
- Branch free condition: `free[i] = ~v[i] | doutReady[i]`.
- `dinReady = &free` (AND over all branches). This is combinational from `doutReady` and `v`, and is independent of `dinValid`.
- Accept: `acc = dinValid & dinReady`.
- Per clock edge, for each branch i:
  - If `acc`: `v[i] <= 1`.
  - Else if `v[i] & doutReady[i]`: `v[i] <= 0`.
  - Else: `v[i]` holds.
- Data register: if `acc`, `dout <= din`; otherwise `dout` holds.
- Branch independence:
  - A branch whose consumer has taken the token stays at `v[i] = 0`.
  - Other branches keep `v = 1` with stable `dout` until their own handshake.
- Stability rule: while any `v[i] = 1`, `dout` is stable unless that same cycle's `acc` replaces the token. This only happens when every pending branch is handing off in that cycle.
- `doutReady[i]` while `v[i] = 0` is ignored.
- `dinValid = 0` with `dinReady = 1` is not an accept; no state change besides branch drains.
- `numOutputs = 1` degenerates to a one-stage pipeline register with full throughput.

## Timing
- Reset values:
  - `v` = all 0, so `doutValid` = 0.
  - `dout` = 0.
  - `dinReady` = 1 as soon as reset deasserts, since all branches are free.
- Reset asserted mid-operation clears all pending branches in the next edge. Tokens held in the fork are dropped. Nothing is accepted during reset cycles; `dinReady` is forced 0 while `reset` = 1.
- Latency: a token accepted at edge N appears on `dout` with `doutValid` = all 1 after edge N, one cycle.
- Throughput:
  - One token per cycle when all `doutReady` = 1 continuously.
  - When any branch stalls, input stalls.
- Simultaneous events:
  - Branch handoff and new accept on the same edge: the accept wins, so `v[i]` = 1 with the new token.
  - No bubble is inserted.
- No combinational path from `din`/`dinValid` to any output.
- The only combinational path is `doutReady` -> `dinReady`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `dinValid` = 1.
  - `doutValid` = 0, `dout` = 0, `dinReady` = 0 during reset.
  - `dinReady` = 1 the cycle after release.
- **Full throughput:** `numOutputs` = 2, all `doutReady` = 11, stream `din` = 1, 2, 3, 4 on consecutive cycles.
  - Each value appears on `dout` one cycle later with `doutValid` = 11.
  - `dinReady` stays 1 throughout.
- **Skewed consumers:** token 0xA5; `doutReady` = 01 for 3 cycles, then 10.
  - Branch 0 drains after cycle 1: `doutValid` = 10.
  - `dinReady` = 0 and `dout` = 0xA5 stable for those 3 cycles.
  - When `doutReady` = 10, `dinReady` = 1 and the next token loads at that edge.
- **Backpressure on all branches:** `doutReady` = 00 for 5 cycles with `dinValid` = 1 and `din` changing every cycle.
  - `dout` holds its first value.
  - `dinReady` = 0 for all 5 cycles.
  - No token lost or duplicated.
- **Mid-operation reset:** `doutValid` = 11 holding 0x3C, assert `reset` 1 cycle.
  - `doutValid` = 00 and `dout` = 0 next cycle.
  - The subsequent token 0x11 flows normally with 1-cycle latency.
- **Random:** random `dinValid`/`doutReady` with `numOutputs` = 4 for 10k cycles.
  - Each branch receives the input sequence exactly once, in order.
  - `dout` never changes while any `doutValid` bit is 1 without all pending branches handing off.

Source files
------------

// File: rtl/dfork_reg_if.sv
// Token stream bundle for dfork_reg: one upstream valid/ready channel and
// numOutputs downstream branches that share a single data bus.
interface dfork_reg_if #(
  parameter int dataWidth  = 32,
  parameter int numOutputs = 2
);
  logic [dataWidth-1:0]  din;
  logic                  dinValid;
  logic                  dinReady;
  logic [dataWidth-1:0]  dout;
  logic [numOutputs-1:0] doutValid;
  logic [numOutputs-1:0] doutReady;

  modport master (output din, dinValid, doutReady, input dinReady, dout, doutValid);
  modport slave  (input din, dinValid, doutReady, output dinReady, dout, doutValid);
endinterface

// File: rtl/dfork_reg.sv
// Registered fork: one input token is broadcast to numOutputs branches, each
// with its own valid bit; a new token is taken only when every branch is free.

module dfork_reg_lane (
  input  logic clock,
  input  logic reset,
  input  logic acc,
  input  logic rdy,
  output logic v,
  output logic free
);
  logic v_q, v_d;

  // A fresh accept overrides a same-cycle handoff, so no bubble is inserted.
  always_comb begin
    v_d = v_q;
    if (acc)             v_d = 1'b1;
    else if (v_q && rdy) v_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign v    = v_q;
  assign free = ~v_q | rdy;
endmodule

module dfork_reg #(
  parameter int dataWidth  = 32,
  parameter int numOutputs = 2
) (
  input  logic        clock,
  input  logic        reset,
  dfork_reg_if.slave  io
);
  logic [numOutputs-1:0] v, free;
  logic [dataWidth-1:0]  dout_q, dout_d;
  logic                  din_ready, acc;

  for (genvar i = 0; i < numOutputs; i++) begin : g_lane
    dfork_reg_lane u_lane (
      .clock (clock),
      .reset (reset),
      .acc   (acc),
      .rdy   (io.doutReady[i]),
      .v     (v[i]),
      .free  (free[i])
    );
  end

  // dinReady depends only on branch state and doutReady, never on dinValid.
  always_comb begin
    din_ready = ~reset & (&free);
    acc       = io.dinValid & din_ready;
    dout_d    = acc ? io.din : dout_q;
  end

  always_ff @(posedge clock) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign io.dinReady  = din_ready;
  assign io.dout      = dout_q;
  assign io.doutValid = v;
endmodule

// File: tb/tb_dfork_reg.sv
// Bench for dfork_reg: a 2-branch fork for directed cases and a 4-branch fork
// for random traffic, both checked every cycle against a token-log model.
module tb_dfork_reg;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dfork_reg_if #(.dataWidth(DW), .numOutputs(2)) ifa ();
  dfork_reg_if #(.dataWidth(DW), .numOutputs(4)) ifb ();

  dfork_reg #(.dataWidth(DW), .numOutputs(2)) dut_a (.clock(clock), .reset(reset), .io(ifa));
  dfork_reg #(.dataWidth(DW), .numOutputs(4)) dut_b (.clock(clock), .reset(reset), .io(ifb));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: every accepted token is appended to a log; branch i has received
  // rx[i] entries of it, so it is pending exactly when rx[i] < log size.
  logic [DW-1:0] log_q [2][$];
  int            rx    [2][4];
  logic [DW-1:0] m_dout[2];
  int            nb    [2] = '{2, 4};

  // Values sampled at the most recent negedge, for the literal checks.
  logic [DW-1:0] s_dout[2];
  logic [3:0]    s_vld [2];
  logic          s_rdy [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv_a(input logic dv, input logic [DW-1:0] d, input logic [1:0] dr);
    ifa.dinValid = dv; ifa.din = d; ifa.doutReady = dr;
  endtask

  // One clock cycle: compare at negedge, advance model, then move past posedge.
  task automatic step();
    logic [3:0]    exp_v, rdy_in;
    logic          exp_rdy, dv;
    logic [DW-1:0] d;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        s_dout[k] = ifa.dout; s_vld[k] = {2'b00, ifa.doutValid}; s_rdy[k] = ifa.dinReady;
        rdy_in = {2'b00, ifa.doutReady}; dv = ifa.dinValid; d = ifa.din;
      end else begin
        s_dout[k] = ifb.dout; s_vld[k] = ifb.doutValid; s_rdy[k] = ifb.dinReady;
        rdy_in = ifb.doutReady; dv = ifb.dinValid; d = ifb.din;
      end
      exp_v = '0;
      for (int i = 0; i < nb[k]; i++) exp_v[i] = (rx[k][i] < log_q[k].size());
      exp_rdy = !reset && ((~exp_v | rdy_in) == 4'hF);
      chk("model_doutValid", 64'(s_vld[k]), 64'(exp_v));
      chk("model_dout",      64'(s_dout[k]), 64'(m_dout[k]));
      chk("model_dinReady",  64'(s_rdy[k]), 64'(exp_rdy));
      if (reset) begin
        for (int i = 0; i < nb[k]; i++) rx[k][i] = log_q[k].size();
        m_dout[k] = '0;
      end else begin
        for (int i = 0; i < nb[k]; i++)
          if (exp_v[i] && rdy_in[i]) begin
            chk("model_order", 64'(s_dout[k]), 64'(log_q[k][rx[k][i]]));
            rx[k][i]++;
          end
        if (dv && exp_rdy) begin
          log_q[k].push_back(d);
          m_dout[k] = d;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = '0;
      for (int i = 0; i < 4; i++) rx[k][i] = 0;
    end
    ifb.dinValid = 1'b0; ifb.din = '0; ifb.doutReady = '0;

    // Reset held 3 cycles with a token offered.
    reset = 1'b1;
    drv_a(1'b1, 32'h77, 2'b00);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("rst_vld",  64'(s_vld[0]), 64'h0);
      chk("rst_dout", 64'(s_dout[0]), 64'h0);
      chk("rst_rdy",  64'(s_rdy[0]), 64'h0);
    end
    reset = 1'b0;
    drv_a(1'b0, 32'h0, 2'b00);
    step();
    chk("post_rst_rdy", 64'(s_rdy[0]), 64'h1);
    chk("post_rst_vld", 64'(s_vld[0]), 64'h0);

    // Full throughput 1..4.
    for (int j = 1; j <= 4; j++) begin
      drv_a(1'b1, DW'(j), 2'b11);
      step();
      chk("tput_rdy", 64'(s_rdy[0]), 64'h1);
      if (j > 1) begin
        chk("tput_dout", 64'(s_dout[0]), 64'(j - 1));
        chk("tput_vld",  64'(s_vld[0]), 64'h3);
      end
    end
    drv_a(1'b0, 32'h0, 2'b11);
    step();
    chk("tput_last_dout", 64'(s_dout[0]), 64'h4);
    chk("tput_last_vld",  64'(s_vld[0]), 64'h3);
    drv_a(1'b0, 32'h0, 2'b00);
    step();
    chk("tput_drained", 64'(s_vld[0]), 64'h0);

    // Skewed consumers.
    drv_a(1'b1, 32'hA5, 2'b00);
    step();
    for (int j = 0; j < 3; j++) begin
      drv_a(1'b1, 32'h5A, 2'b01);
      step();
      chk("skew_vld",  64'(s_vld[0]), (j == 0) ? 64'h3 : 64'h2);
      chk("skew_rdy",  64'(s_rdy[0]), 64'h0);
      chk("skew_dout", 64'(s_dout[0]), 64'hA5);
    end
    drv_a(1'b1, 32'h5A, 2'b10);
    step();
    chk("skew_release_rdy", 64'(s_rdy[0]), 64'h1);
    drv_a(1'b0, 32'h0, 2'b00);
    step();
    chk("skew_next_dout", 64'(s_dout[0]), 64'h5A);
    chk("skew_next_vld",  64'(s_vld[0]), 64'h3);

    // Backpressure on both branches.
    for (int j = 0; j < 5; j++) begin
      drv_a(1'b1, 32'h100 + DW'(j), 2'b00);
      step();
      chk("bp_rdy",  64'(s_rdy[0]), 64'h0);
      chk("bp_dout", 64'(s_dout[0]), 64'h5A);
      chk("bp_vld",  64'(s_vld[0]), 64'h3);
    end
    drv_a(1'b0, 32'h0, 2'b11);
    step();
    drv_a(1'b0, 32'h0, 2'b00);
    step();
    chk("bp_drained", 64'(s_vld[0]), 64'h0);

    // Mid-operation reset drops the held token.
    drv_a(1'b1, 32'h3C, 2'b00);
    step();
    drv_a(1'b0, 32'h0, 2'b00);
    step();
    chk("mid_held_dout", 64'(s_dout[0]), 64'h3C);
    chk("mid_held_vld",  64'(s_vld[0]), 64'h3);
    reset = 1'b1;
    step();
    chk("mid_rst_rdy", 64'(s_rdy[0]), 64'h0);
    reset = 1'b0;
    step();
    chk("mid_after_vld",  64'(s_vld[0]), 64'h0);
    chk("mid_after_dout", 64'(s_dout[0]), 64'h0);
    chk("mid_after_rdy",  64'(s_rdy[0]), 64'h1);
    drv_a(1'b1, 32'h11, 2'b00);
    step();
    drv_a(1'b0, 32'h0, 2'b11);
    step();
    chk("mid_next_dout", 64'(s_dout[0]), 64'h11);
    chk("mid_next_vld",  64'(s_vld[0]), 64'h3);

    // Random traffic on both forks.
    for (int j = 0; j < 10000; j++) begin
      drv_a(1'($urandom_range(0, 3) != 0), DW'($urandom), 2'($urandom));
      ifb.dinValid  = 1'($urandom_range(0, 3) != 0);
      ifb.din       = DW'($urandom);
      ifb.doutReady = 4'($urandom) | 4'($urandom);
      step();
    end
    drv_a(1'b0, 32'h0, 2'b11);
    ifb.dinValid = 1'b0; ifb.doutReady = 4'hF;
    step();
    step();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < nb[k]; i++)
        chk("rand_all_delivered", 64'(rx[k][i]), 64'(log_q[k].size()));
    chk("rand_b_vld_idle", 64'(s_vld[1]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
